// File: rtl/step_seq_scheduler_if.sv
// Register bus of the step sequencer: a single-cycle select/write-enable port
// with a registered read-data return.
interface step_seq_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              sel;
  logic              we;
  logic [3:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, we, addr, data_in, input data_out);
  modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/step_seq_scheduler.sv
// 8-step tone sequencer: CPU-programmed half-period table and tempo. It plays a
// square wave per step and drives a one-hot step LED bus.
module step_seq_scheduler #(
  parameter int DATA_W  = 32,
  parameter int FREQ_W  = 16,
  parameter int TEMPO_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  step_seq_scheduler_if.slave  bus,
  input  logic [7:0]           step_mask,
  output logic                 snd_out,
  output logic [7:0]           led_out,
  output logic                 step_tick,
  output logic                 state_dbg
);
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [FREQ_W-1:0]  freq [8];
  logic [TEMPO_W-1:0] tempo, tempo_lat, step_cnt;
  logic [FREQ_W-1:0]  tone_cnt;
  logic               ctrl_loop;
  logic [2:0]         ctrl_last;
  logic               done;
  logic [2:0]         step;
  logic               snd_raw;

  logic               wr, rd, ctrl_wr;
  logic               start, stop, step_end, last_step;
  logic [TEMPO_W-1:0] tempo_eff;
  logic [FREQ_W-1:0]  cur_freq;
  logic [DATA_W-1:0]  rd_data;
  logic               unused_hi;

  // Bus handshake: sel qualifies a one-cycle transfer and the block is always
  // ready. sel&we writes at this edge; sel&~we loads data_out at this edge,
  // so read data is valid the following cycle and held until the next read.
  assign wr        = bus.sel & bus.we;
  assign rd        = bus.sel & ~bus.we;
  assign ctrl_wr   = wr && (bus.addr == 4'd8);
  assign tempo_eff = (tempo == '0) ? TEMPO_W'(1) : tempo;
  assign cur_freq  = freq[step];
  assign last_step = (step >= ctrl_last);
  assign unused_hi = ^bus.data_in[DATA_W-1:TEMPO_W];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    step_end  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && bus.data_in[0]) begin
          start     = 1'b1;
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        // A CTRL write beats a coincident step end.
        if (ctrl_wr) begin
          if (bus.data_in[0]) begin
            start = 1'b1;
          end else begin
            stop      = 1'b1;
            state_nxt = IDLE;
          end
        end else if (step_cnt == tempo_lat - TEMPO_W'(1)) begin
          step_end = 1'b1;
          if (last_step && !ctrl_loop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) freq[i] <= '0;
      tempo        <= '0;
      tempo_lat    <= '0;
      step_cnt     <= '0;
      tone_cnt     <= '0;
      ctrl_loop    <= 1'b0;
      ctrl_last    <= '0;
      done         <= 1'b0;
      step         <= '0;
      snd_raw      <= 1'b0;
      step_tick    <= 1'b0;
      bus.data_out <= '0;
    end else begin
      step_tick <= step_end;
      if (wr && !bus.addr[3])       freq[bus.addr[2:0]] <= bus.data_in[FREQ_W-1:0];
      if (wr && bus.addr == 4'd9)   tempo <= bus.data_in[TEMPO_W-1:0];
      if (ctrl_wr) begin
        ctrl_loop <= bus.data_in[1];
        ctrl_last <= bus.data_in[4:2];
      end
      if (start) begin
        done      <= 1'b0;
        step      <= '0;
        step_cnt  <= '0;
        tone_cnt  <= '0;
        snd_raw   <= 1'b0;
        tempo_lat <= tempo_eff;
      end else if (stop) begin
        step     <= '0;
        step_cnt <= '0;
        tone_cnt <= '0;
        snd_raw  <= 1'b0;
      end else if (step_end) begin
        step_cnt  <= '0;
        tone_cnt  <= '0;
        snd_raw   <= 1'b0;
        tempo_lat <= tempo_eff;
        if (!last_step)     step <= step + 3'd1;
        else if (ctrl_loop) step <= '0;
        else begin
          step <= '0;
          done <= 1'b1;
        end
      end else if (state == PLAY) begin
        step_cnt <= step_cnt + TEMPO_W'(1);
        // A silent step (FREQ=0) keeps counting; the output gate mutes it.
        if (tone_cnt == cur_freq - FREQ_W'(1)) begin
          tone_cnt <= '0;
          snd_raw  <= ~snd_raw;
        end else begin
          tone_cnt <= tone_cnt + FREQ_W'(1);
        end
      end
      if (rd) bus.data_out <= rd_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (!bus.addr[3]) begin
      rd_data = DATA_W'(freq[bus.addr[2:0]]);
    end else begin
      case (bus.addr[2:0])
        3'd0:    rd_data = DATA_W'({ctrl_last, ctrl_loop, state == PLAY});
        3'd1:    rd_data = DATA_W'(tempo);
        3'd2:    rd_data = DATA_W'({done, state == PLAY, step});
        default: rd_data = '0;
      endcase
    end
  end

  assign snd_out   = snd_raw && (state == PLAY) && (cur_freq != '0) && step_mask[step];
  assign led_out   = (state == PLAY) ? (8'd1 << step) : 8'd0;
  assign state_dbg = (state == PLAY);
endmodule

// File: tb/tb_step_seq_scheduler.sv
// Bench for step_seq_scheduler: directed scenarios plus random register traffic,
// checked every cycle against an elapsed-time model of the sequencer.
module tb_step_seq_scheduler;
  localparam int DATA_W = 32, FREQ_W = 16, TEMPO_W = 24;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  step_seq_scheduler_if #(.DATA_W(DATA_W)) bus ();
  logic [7:0] step_mask;
  logic [7:0] led_out;
  logic       snd_out, step_tick, state_dbg;

  step_seq_scheduler #(.DATA_W(DATA_W), .FREQ_W(FREQ_W), .TEMPO_W(TEMPO_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .step_mask(step_mask),
    .snd_out(snd_out), .led_out(led_out), .step_tick(step_tick), .state_dbg(state_dbg)
  );

  // reference model: playback described by elapsed cycles within the step
  int          m_freq [8];
  int          m_tempo, m_last, m_loop, m_play, m_done, m_step, m_e, m_lat, m_tick;
  logic [31:0] m_rd;
  logic [31:0] exp_q[$];
  int          n_checks = 0, n_pass = 0;
  int          tick_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_freq[i] = 0;
    m_tempo = 0; m_last = 0; m_loop = 0; m_play = 0; m_done = 0;
    m_step = 0; m_e = 0; m_lat = 0; m_tick = 0; m_rd = '0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < 8)   return 32'(m_freq[a]);
    if (a == 8)  return 32'((m_last << 2) | (m_loop << 1) | m_play);
    if (a == 9)  return 32'(m_tempo);
    if (a == 10) return 32'((m_done << 4) | (m_play << 3) | m_step);
    return '0;
  endfunction

  task automatic model_edge();
    logic        wr = bus.sel & bus.we;
    logic        rd = bus.sel & ~bus.we;
    int          a  = int'(bus.addr);
    logic [31:0] d  = bus.data_in;
    int          t_eff = (m_tempo == 0) ? 1 : m_tempo;
    if (rd) begin
      m_rd = model_read(a);
      exp_q.push_back(m_rd);
    end
    m_tick = 0;
    if (wr && a == 8) begin
      m_loop = int'(d[1]);
      m_last = int'(d[4:2]);
      if (d[0]) begin
        m_play = 1; m_done = 0; m_step = 0; m_e = 0; m_lat = t_eff;
      end else if (m_play == 1) begin
        m_play = 0; m_step = 0; m_e = 0;
      end
    end else if (m_play == 1) begin
      if (m_e == m_lat - 1) begin
        m_tick = 1; m_e = 0; m_lat = t_eff;
        if (m_step < m_last)  m_step++;
        else if (m_loop == 1) m_step = 0;
        else begin
          m_play = 0; m_done = 1; m_step = 0;
        end
      end else begin
        m_e++;
      end
    end
    if (wr && a < 8)  m_freq[a] = int'(d[FREQ_W-1:0]);
    if (wr && a == 9) m_tempo = int'(d[TEMPO_W-1:0]);
  endtask

  function automatic logic exp_snd();
    int f = m_freq[m_step];
    if (m_play == 0 || f == 0 || !step_mask[m_step]) return 1'b0;
    return ((m_e / f) % 2) == 1;
  endfunction

  // one clock: model follows the edge, outputs compared at the falling edge
  task automatic cycle();
    logic [7:0] one = 8'd1;
    logic       had_rd = bus.sel & ~bus.we;
    @(posedge clk);
    model_edge();
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    @(negedge clk);
    check("snd_out", 32'(snd_out), 32'(exp_snd()));
    check("led_out", 32'(led_out), (m_play == 1) ? 32'(one << m_step) : 32'd0);
    check("step_tick", 32'(step_tick), 32'(m_tick));
    check("state_dbg", 32'(state_dbg), 32'(m_play));
    if (step_tick) tick_seen++;
    if (had_rd) begin
      while (exp_q.size() > 0) check("read_data", bus.data_out, exp_q.pop_front());
    end else begin
      check("data_hold", bus.data_out, m_rd);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    cycle();
  endtask

  task automatic bus_read(input logic [3:0] a);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a; bus.data_in = '0;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic hard_reset();
    rst = 1'b0;
    model_reset();
    #3;
    check("rst_snd", 32'(snd_out), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_tick", 32'(step_tick), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ok;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    step_mask = 8'hFF;
    tick_seen = 0;
    #2;
    hard_reset();
    bus_read(4'd10);
    bus_read(4'd8);

    // single step tone/tempo, ends in IDLE with DONE
    bus_write(4'd0, 32'd3);
    bus_write(4'd9, 32'd12);
    tick_seen = 0;
    bus_write(4'd8, 32'h1);
    idle(14);
    check("t2_ticks", 32'(tick_seen), 32'd1);
    bus_read(4'd10);
    check("t2_status", bus.data_out, 32'h10);

    // looping three steps, then the same with step 1 muted
    bus_write(4'd0, 32'd2);
    bus_write(4'd1, 32'd4);
    bus_write(4'd2, 32'd0);
    bus_write(4'd9, 32'd8);
    bus_write(4'd8, 32'h0B);
    idle(34);
    step_mask = 8'hFD;
    bus_write(4'd8, 32'h0B);
    idle(34);
    step_mask = 8'hFF;

    // stop written on the step-end cycle
    bus_write(4'd9, 32'd4);
    bus_write(4'd8, 32'h03);
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (m_play == 1 && m_e == m_lat - 1) ok = 1;
      else cycle();
    end
    check("t5_found_end", 32'(ok), 32'd1);
    bus_write(4'd8, 32'h0);
    check("t5_no_tick", 32'(step_tick), 32'd0);
    bus_read(4'd10);
    check("t5_status", bus.data_out, 32'h0);

    // edge values: tempo 0, freq 1, unmapped address
    for (int i = 0; i < 8; i++) bus_write(4'(i), 32'd1);
    bus_write(4'd9, 32'd0);
    bus_write(4'd8, 32'h1F);
    idle(20);
    bus_write(4'd9, 32'd10);
    bus_write(4'd8, 32'h01);
    idle(12);
    bus_write(4'd15, 32'hFFFF_FFFF);
    bus_read(4'd15);
    check("unmapped_read", bus.data_out, 32'h0);
    for (int a = 0; a < 11; a++) bus_read(4'(a));

    // random register traffic with live mask changes
    for (int it = 0; it < 700; it++) begin
      int op = $urandom_range(0, 9);
      if (op == 0) step_mask = 8'($urandom);
      if (op <= 3) begin
        cycle();
      end else if (op == 4) begin
        bus_read(4'($urandom_range(0, 15)));
      end else if (op == 5) begin
        int a = $urandom_range(0, 7);
        if (m_play == 1 && a == m_step) cycle();
        else bus_write(4'(a), 32'($urandom_range(0, 5)));
      end else if (op == 6) begin
        bus_write(4'd9, 32'($urandom_range(0, 6)));
      end else if (op == 7 && $urandom_range(0, 3) == 0) begin
        logic [31:0] c = 32'($urandom_range(0, 31));
        bus_write(4'd8, c);
      end else if (op == 8 && m_play == 0) begin
        logic [31:0] c = 32'($urandom_range(0, 15)) << 1;
        bus_write(4'd8, c | 32'h1);
      end else begin
        bus_write(4'($urandom_range(11, 15)), 32'($urandom));
      end
    end

    // async reset while the tone is high
    step_mask = 8'hFF;
    bus_write(4'd0, 32'd2);
    bus_write(4'd9, 32'd50);
    bus_write(4'd8, 32'h01);
    bus_read(4'd0);
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (snd_out === 1'b1) ok = 1;
      else cycle();
    end
    check("t1_snd_high", 32'(ok), 32'd1);
    #2;
    hard_reset();
    bus_read(4'd10);
    check("t1_status", bus.data_out, 32'h0);
    bus_read(4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
